// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types, memory depth and address-rule helper for the
// data-memory port arbiter.
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam int unsigned MEM_DEPTH = 512;

  // Word 0 is reserved and anything past the array is unmapped.
  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr != 32'd0) && (addr < 32'(MEM_DEPTH));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: CPU-first grant decision with a saturating DMA wait counter
// that lets a starved DMA requester overtake the CPU.
`default_nettype none

module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int WCNT_W       = 3
) (
  input  logic   Clk,
  input  logic   Reset_n,
  input  logic   arb_en,
  input  logic   cpu_req,
  input  logic   dma_req,
  input  owner_e owner,
  output logic   grant_cpu,
  output logic   grant_dma
);

  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              cpu_req_m, dma_req_m, starved;

  always_comb begin
    // The port being acked this cycle must not win again on its stale req.
    cpu_req_m  = cpu_req & (owner != OWN_CPU);
    dma_req_m  = dma_req & (owner != OWN_DMA);
    starved    = (wait_cnt_q >= WCNT_W'(STARVE_LIMIT));
    grant_dma  = arb_en & dma_req_m & (~cpu_req_m | starved);
    grant_cpu  = arb_en & cpu_req_m & ~grant_dma;

    wait_cnt_d = wait_cnt_q;
    if (grant_dma || !dma_req) begin
      wait_cnt_d = '0;
    end else if ((owner != OWN_DMA) && !starved) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises CPU and DMA accesses onto the 512x32 data memory.
// Optional MEM_PORT_ARB_PERF_EN adds per-port access and CPU stall counters.
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int STARVE_LIMIT = 4,
  parameter int WCNT_W       = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic [31:0]       dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              range_err
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0]       perf_cpu_cnt,
  output logic [31:0]       perf_dma_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d, bad_q, bad_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
  logic              range_err_q, range_err_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;

  logic              w_arb_en, w_grant_cpu, w_grant_dma;
  logic              w_sel_we, w_sel_ok;
  logic [31:0]       w_sel_addr, w_sel_wdata, w_resp_data;

  assign w_arb_en = (state_q == IDLE) || (state_q == RESP);

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .WCNT_W       (WCNT_W)
  ) u_prio (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .arb_en    (w_arb_en),
    .cpu_req   (cpu_req),
    .dma_req   (dma_req),
    .owner     (owner_q),
    .grant_cpu (w_grant_cpu),
    .grant_dma (w_grant_dma)
  );

  assign w_sel_we    = w_grant_dma ? dma_we    : cpu_we;
  assign w_sel_addr  = w_grant_dma ? dma_addr  : cpu_addr;
  assign w_sel_wdata = w_grant_dma ? dma_wdata : cpu_wdata;
  assign w_sel_ok    = addr_ok(w_sel_addr);
  assign w_resp_data = (!we_q && !bad_q) ? mem_rdata : 32'd0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    bad_d       = bad_q;
    mem_addr_d  = '0;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    range_err_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      ISSUE: begin
        state_d     = RESP;
        cpu_ack_d   = (owner_q == OWN_CPU);
        dma_ack_d   = (owner_q == OWN_DMA);
        range_err_d = bad_q;
      end
      RESP: begin
        if (owner_q == OWN_CPU) cpu_rdata_d = w_resp_data;
        if (owner_q == OWN_DMA) dma_rdata_d = w_resp_data;
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: ;
    endcase

    // A grant loads the memory strobes so they are presented during ISSUE.
    if (w_arb_en && (w_grant_cpu || w_grant_dma)) begin
      state_d     = ISSUE;
      owner_d     = w_grant_dma ? OWN_DMA : OWN_CPU;
      we_d        = w_sel_we;
      bad_d       = ~w_sel_ok;
      mem_addr_d  = w_sel_addr[ADDR_W-1:0];
      mem_re_d    = w_sel_ok & ~w_sel_we;
      mem_we_d    = w_sel_ok & w_sel_we;
      mem_wdata_d = w_sel_wdata;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      range_err_q <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      bad_q       <= bad_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      range_err_q <= range_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Memory data is only valid in RESP, so the ack cycle bypasses the holding flop.
  assign cpu_rdata = cpu_ack_q ? w_resp_data : cpu_rdata_q;
  assign dma_rdata = dma_ack_q ? w_resp_data : dma_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign range_err = range_err_q;

`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_cpu_q, perf_cpu_d, perf_dma_q, perf_dma_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cpu_d   = perf_cpu_q   + {31'd0, cpu_ack_q};
    perf_dma_d   = perf_dma_q   + {31'd0, dma_ack_q};
    perf_stall_d = perf_stall_q + {31'd0, cpu_stall};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      perf_cpu_q   <= '0;
      perf_dma_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_cpu_q   <= perf_cpu_d;
      perf_dma_q   <= perf_dma_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_cpu_cnt   = perf_cpu_q;
  assign perf_dma_cnt   = perf_dma_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

`default_nettype wire
